// File: rtl/dff_sync_rst.sv
// Rising-edge register chain (WIDTH bits, STAGES deep) with synchronous active-high reset to RST_VAL.
// Latency: STAGES clk edges from d to q. No flow control: the chain shifts on every edge.
module dff_sync_rst #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      STAGES  = 1,
  parameter logic [1023:0]    RST_VAL = '0
) (
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             rst
);

  if ((WIDTH < 1) || (WIDTH > 1024)) begin : g_bad_width
    $fatal(1, "dff_sync_rst: WIDTH %0d outside 1..1024", WIDTH);
  end

  if ((STAGES < 1) || (STAGES > 16)) begin : g_bad_stages
    $fatal(1, "dff_sync_rst: STAGES %0d outside 1..16", STAGES);
  end

  // A reset value that does not fit the data path is a configuration error.
  if ((WIDTH < 1024) && ((RST_VAL >> WIDTH) != '0)) begin : g_bad_rst_val
    $fatal(1, "dff_sync_rst: RST_VAL has bits set above WIDTH");
  end

  localparam logic [WIDTH-1:0] RST_WORD = RST_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RST_WORD;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: tb/tb_dff_sync_rst.sv
// Checks a default 1-bit flop and an 8-bit, 3-stage, RST_VAL=A5 chain against a queue-based reference.
module tb_dff_sync_rst;

  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       d0, rst0, q0;
  logic [7:0] d8, q8;
  logic       rst8;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: expected contents of each pipeline, oldest entry at the front; -1 means unknown.
  int exp0 = -1;
  int pipe8[$];

  dff_sync_rst u_dut0 (
    .q   (q0),
    .d   (d0),
    .clk (clk),
    .rst (rst0)
  );

  dff_sync_rst #(.WIDTH(8), .STAGES(3), .RST_VAL(RV)) u_dut8 (
    .q   (q8),
    .d   (d8),
    .clk (clk),
    .rst (rst8)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rise();
    #5 clk = 1'b1;
    exp0 = rst0 ? 0 : int'(d0);
    if (rst8) begin
      pipe8 = '{int'(RV), int'(RV), int'(RV)};
    end else begin
      pipe8.push_back(int'(d8));
      void'(pipe8.pop_front());
    end
    #1;
  endtask

  task automatic fall();
    #4 clk = 1'b0;
    #1;
  endtask

  task automatic chk_model(input string tag);
    int e8;
    if (exp0 >= 0) check({tag, "_q0"}, {7'd0, q0}, exp0[7:0]);
    e8 = pipe8[0];
    if (e8 >= 0) check({tag, "_q8"}, q8, e8[7:0]);
  endtask

  task automatic glitch_inputs();
    d0   = 1'($urandom);
    rst0 = 1'($urandom);
    d8   = 8'($urandom);
    rst8 = 1'($urandom);
  endtask

  initial begin
    pipe8 = '{-1, -1, -1};

    // First edge: default flop loads 0, wide chain takes its reset.
    d0 = 1'b0; rst0 = 1'b0; rst8 = 1'b1; d8 = 8'h3C;
    rise();
    check("first_edge_q0", {7'd0, q0}, 8'h00);
    check("reset_q8", q8, RV);
    fall();

    // d=1 captured; then rst raised with clk held high must not reset.
    d0 = 1'b1; rst8 = 1'b0; d8 = 8'h01;
    rise();
    check("load1_q0", {7'd0, q0}, 8'h01);
    check("lat1_q8", q8, RV);
    rst0 = 1'b1; rst8 = 1'b1;
    #2;
    check("hold_hi_rst_q0", {7'd0, q0}, 8'h01);
    check("hold_hi_rst_q8", q8, RV);
    rst8 = 1'b0;
    fall();
    check("fall_rst_q0", {7'd0, q0}, 8'h01);

    // Reset wins over d=1.
    d0 = 1'b1; rst0 = 1'b1; d8 = 8'h02;
    rise();
    check("rst_wins_q0", {7'd0, q0}, 8'h00);
    check("lat2_q8", q8, RV);
    fall();

    rst0 = 1'b0; d0 = 1'b1; d8 = 8'h03;
    rise();
    check("release_q0", {7'd0, q0}, 8'h01);
    check("lat3_q8", q8, 8'h01);
    fall();

    // d toggling with clk low changes nothing.
    d0 = 1'b0; #1 check("low_d0_q0", {7'd0, q0}, 8'h01);
    d0 = 1'b1; #1 check("low_d1_q0", {7'd0, q0}, 8'h01);
    d0 = 1'b0; #1 check("low_d2_q0", {7'd0, q0}, 8'h01);

    // Load 0x11, then toggle everything while clk is high and across the falling edge.
    d8 = 8'h11;
    rise();
    check("load0_q0", {7'd0, q0}, 8'h00);
    check("shift_q8_02", q8, 8'h02);
    d0 = 1'b1; d8 = 8'hFF; #1;
    check("hi_d_q0", {7'd0, q0}, 8'h00);
    check("hi_d_q8", q8, 8'h02);
    fall();
    check("fall_d_q0", {7'd0, q0}, 8'h00);
    check("fall_d_q8", q8, 8'h02);

    // 0x11 and 0x22 in flight, then a one-edge reset flushes them.
    d0 = 1'b0; d8 = 8'h22;
    rise();
    check("shift_q8_03", q8, 8'h03);
    fall();
    rst8 = 1'b1; d8 = 8'h77;
    rise();
    check("flush_q8", q8, RV);
    fall();
    rst8 = 1'b0; d8 = 8'h33;
    rise(); check("post_flush1_q8", q8, RV); fall();
    d8 = 8'h44;
    rise(); check("post_flush2_q8", q8, RV); fall();
    d8 = 8'h55;
    rise(); check("post_flush3_q8", q8, 8'h33); fall();

    // Random traffic with occasional resets and input glitches between edges.
    for (int i = 0; i < 400; i++) begin
      d0   = 1'($urandom);
      d8   = 8'($urandom);
      rst0 = ($urandom_range(0, 9) == 0);
      rst8 = ($urandom_range(0, 9) == 0);
      rise();
      chk_model("rnd_edge");
      glitch_inputs();
      #1 chk_model("rnd_hi");
      fall();
      glitch_inputs();
      #1 chk_model("rnd_lo");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_sync_rst.md
Name: dff_sync_rst

Overview:
- Rising-edge D flip-flop with synchronous, active-high reset; general-purpose storage/retiming element.
- Default configuration is a single 1-bit flop.
- Parameters widen the data path and insert extra retiming stages.
- Port list order is fixed at q, d, clk, rst, so existing positional instantiations bind correctly.

Parameters:
- WIDTH, 1, data width of d and q in bits (legal range 1 to 1024).
- STAGES, 1, number of cascaded register stages from d to q (legal range 1 to 16).
- RST_VAL, 0 (all zeros, WIDTH bits), value loaded into every stage on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge only.
- rst  input  1  synchronous reset, active-high; sampled only at a clk rising edge.
- q  output  WIDTH  registered output, driven directly by the last stage.
- d  input  WIDTH  data input, sampled at a clk rising edge.
- Declaration order in the module header is q, d, clk, rst. The clock and reset are fixed as one clock (clk) with synchronous, active-high reset (rst).

Behaviour:
- Each stage is a WIDTH-bit register: stage[0] loads d; stage[i] loads stage[i-1]; q = stage[STAGES-1].
- At a clk rising edge with rst=1: every stage loads RST_VAL. q equals RST_VAL immediately after that edge; d is ignored.
- At a clk rising edge with rst=0: the pipeline shifts by one stage.
- Latency from d to q is exactly STAGES rising edges. With defaults, q takes d's value at the edge.
- Reset is strictly synchronous:
  - rst asserting or deasserting between edges has no effect on q.
  - A level change of rst while clk is held high or low changes nothing.
- Level changes on d or clk without a rising edge (clk held high, or a falling edge) never change q.
- Simultaneous rst=1 and d change at the same edge: reset wins, and q gets RST_VAL.
- Reset mid-operation clears all in-flight data in every stage in one edge. After rst deasserts, q shows RST_VAL until new data has propagated through STAGES edges.
- Power-up: stage contents and q are undefined (X in simulation) until the first rising edge with rst=1, or until STAGES edges with rst=0 and known d. No initial blocks for synthesis.
- No combinational path from d or rst to q. q is purely a register output.
- Elaboration checks: a WIDTH or STAGES value outside its legal range is a fatal error. An RST_VAL with nonzero bits above WIDTH is a fatal error.

Test Plan:
- Defaults, d=0 rst=0, clk 0->1 -> q=0 after the edge, undefined before it.
- Defaults, q=0; d=1 rst=0, clk rising edge -> q=1. Then clk held at 1 with rst raised to 1 -> q stays 1 (no edge, so no reset).
- Defaults, q=1; rst=1 d=1, clk rising edge -> q=0. Release rst with d=1, next rising edge -> q=1.
- Defaults, d toggled 0->1->0 while clk is held low and then falls -> q unchanged throughout.
- WIDTH=8 STAGES=3 RST_VAL=8'hA5:
  - reset edge -> q=8'hA5.
  - then d=8'h01, 8'h02, 8'h03 on successive edges -> q=8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03 (3-edge latency).
- WIDTH=8 STAGES=3: rst=1 asserted for one edge while 8'h11 and 8'h22 are in flight -> q=RST_VAL at that edge. Both values are lost, and q stays RST_VAL for the next 2 edges.
